// File: rtl/rf_checker.sv
// Register-file checker: scans NUM_REGS registers through a combinational read
// port, compares each against a loadable expected table and streams one result beat per register.
module rf_checker #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              exp_we,
  input  logic [4:0]        exp_addr,
  input  logic [DATA_W-1:0] exp_wdata,
  input  logic              start,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_idx,
  output logic [DATA_W-1:0] out_actual,
  output logic              out_match,
  output logic              busy,
  output logic              done,
  output logic [5:0]        errors,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t            state_q;
  logic [4:0]        idx_q;
  logic [DATA_W-1:0] actual_q;
  logic              match_q;
  logic [5:0]        errors_q;
  logic              match_d;

  // Expected table has no reset: its contents are only meaningful once written.
  logic [DATA_W-1:0] exp_tab [NUM_REGS];

  always_ff @(posedge clk) begin
    if (exp_we && !busy && (int'(exp_addr) < NUM_REGS)) begin
      exp_tab[exp_addr] <= exp_wdata;
    end
  end

  assign match_d = (rf_rdata == exp_tab[idx_q]);

  // Handshake: a beat is offered while out_valid=1 with fields held stable, and is
  // consumed on the rising edge where out_valid and out_ready are both 1.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      actual_q <= '0;
      match_q  <= 1'b0;
      errors_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            errors_q <= '0;
            idx_q    <= '0;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          actual_q <= rf_rdata;
          match_q  <= match_d;
          if (!match_d) begin
            errors_q <= errors_q + 6'd1;
          end
          state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= S_ISSUE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rf_raddr    = (state_q == S_ISSUE || state_q == S_CAPTURE) ? idx_q : 5'd0;
  assign out_valid   = (state_q == S_EMIT);
  assign busy        = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_EMIT);
  assign done        = (state_q == S_DONE);
  assign out_idx     = idx_q;
  assign out_actual  = actual_q;
  assign out_match   = match_q;
  assign errors      = errors_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rf_checker.sv
// Directed bench for rf_checker: a combinational register-file model, hand-picked
// data patterns and expected error counts, and a queue of expected beat values.
module tb_rf_checker;

  localparam int N = 32;
  localparam int W = 32;

  logic         clk;
  logic         rstb;
  logic         exp_we;
  logic [4:0]   exp_addr;
  logic [W-1:0] exp_wdata;
  logic         start;
  logic [4:0]   rf_raddr;
  logic [W-1:0] rf_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_idx;
  logic [W-1:0] out_actual;
  logic         out_match;
  logic         busy;
  logic         done;
  logic [5:0]   errors;
  logic [2:0]   dbg_state;

  logic [W-1:0] rf_mem  [N];
  logic [W-1:0] tab_mdl [N];
  logic [W-1:0] exp_q [$];

  int n_checks;
  int n_errors;
  int beats;
  int cycles;

  rf_checker #(.NUM_REGS(N), .DATA_W(W)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .exp_we      (exp_we),
    .exp_addr    (exp_addr),
    .exp_wdata   (exp_wdata),
    .start       (start),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_actual  (out_actual),
    .out_match   (out_match),
    .busy        (busy),
    .done        (done),
    .errors      (errors),
    .dbg_state_o (dbg_state)
  );

  assign rf_rdata = rf_mem[rf_raddr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  W'(out_valid), 0);
    check({tag, "_busy"},   W'(busy), 0);
    check({tag, "_done"},   W'(done), 0);
    check({tag, "_errors"}, W'(errors), 0);
    check({tag, "_raddr"},  W'(rf_raddr), 0);
    check({tag, "_idx"},    W'(out_idx), 0);
    check({tag, "_actual"}, out_actual, 0);
    check({tag, "_match"},  W'(out_match), 0);
  endtask

  task automatic write_exp(input logic [4:0] a, input logic [W-1:0] d);
    @(negedge clk);
    exp_we = 1'b1; exp_addr = a; exp_wdata = d;
    @(posedge clk);
    #1;
    exp_we = 1'b0;
    tab_mdl[a] = d;
  endtask

  // mode: 0 plain, 1 random stalls, 2 disturb mid-scan, 3 reset at beat 10
  task automatic run_scan(input int mode, input int exp_err, output int nbeats, output int ncyc);
    int  stall_left;
    bit  fresh;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(rf_mem[i]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nbeats = 0; ncyc = 0; stall_left = 0; fresh = 1'b1;
    while (ncyc < 2000) begin
      @(posedge clk);
      ncyc++;
      #1;
      if (mode == 2 && ncyc == 21) begin
        start = 1'b0; exp_we = 1'b0;
      end
      if (mode == 2 && ncyc == 20) begin
        start = 1'b1; exp_we = 1'b1; exp_addr = 5'd3; exp_wdata = '1;
      end
      if (done) break;
      if (out_valid) begin
        if (mode == 3 && nbeats == 10) begin
          rstb = 1'b0;
          #1;
          check_reset_outputs("midscan_rst");
          return;
        end
        check("beat_idx",    W'(out_idx), W'(nbeats));
        check("beat_actual", out_actual, exp_q[0]);
        check("beat_match",  W'(out_match), W'(exp_q[0] == tab_mdl[nbeats]));
        if (fresh) begin
          stall_left = (mode == 1) ? $urandom_range(0, 7) : 0;
          fresh = 1'b0;
        end
        if (stall_left == 0) begin
          out_ready = 1'b1;
          void'(exp_q.pop_front());
          nbeats++;
          fresh = 1'b1;
        end else begin
          out_ready = 1'b0;
          stall_left--;
        end
      end
    end
    out_ready = 1'b1;
    check("scan_done",   W'(done), 1);
    check("scan_beats",  W'(nbeats), N);
    check("scan_errors", W'(errors), W'(exp_err));
    check("done_busy",   W'(busy), 0);
    check("done_valid",  W'(out_valid), 0);
    check("done_raddr",  W'(rf_raddr), 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rstb = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) rf_mem[i] = W'(i);
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rstb = 1'b1;

    for (int i = 0; i < N; i++) write_exp(5'(i), W'(i));

    // all registers match, done after exactly 3 cycles per register
    run_scan(0, 0, beats, cycles);
    check("scan1_cycles", W'(cycles), 96);

    // r5 and r31 corrupted
    rf_mem[5]  = 32'hDEADBEEF;
    rf_mem[31] = 32'hDEADBEEF;
    run_scan(0, 2, beats, cycles);

    // random consumer stalls
    rf_mem[5]  = 32'd5;
    rf_mem[31] = 32'd31;
    run_scan(1, 0, beats, cycles);

    // start and table write while busy must be ignored
    rf_mem[5] = 32'hDEADBEEF;
    run_scan(2, 1, beats, cycles);
    rf_mem[5] = 32'd5;

    // reset mid-scan, then a clean full scan (also shows table[3] kept its value)
    run_scan(3, 0, beats, cycles);
    check("rst_beats_before", W'(beats), 10);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rstb = 1'b1;
    run_scan(0, 0, beats, cycles);
    check("post_rst_cycles", W'(cycles), 96);

    // back-to-back: every register wrong, then all correct
    for (int i = 0; i < N; i++) rf_mem[i] = ~W'(i);
    run_scan(0, 32, beats, cycles);
    repeat (5) @(posedge clk);
    #1;
    check("between_done",   W'(done), 1);
    check("between_errors", W'(errors), 32);
    check("between_busy",   W'(busy), 0);
    for (int i = 0; i < N; i++) rf_mem[i] = W'(i);
    run_scan(0, 0, beats, cycles);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_checker.md
RF_CHECKER -- requirements
Module: rf_checker

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers scanned.
REQ-002 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstb  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port exp_we  input  1  write strobe for the expected-value table.
REQ-006 SHALL have port exp_addr  input  5  expected-table write index.
REQ-007 SHALL have port exp_wdata  input  DATA_W  expected value to store.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a scan.
REQ-009 SHALL have port rf_raddr  output  5  register-file read address.
REQ-010 SHALL have port rf_rdata  input  DATA_W  register-file read data, combinational on rf_raddr.
REQ-011 SHALL have port out_valid  output  1  result beat available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-013 SHALL have port out_idx  output  5  register index of the beat.
REQ-014 SHALL have port out_actual  output  DATA_W  captured register value.
REQ-015 SHALL have port out_match  output  1  1 when out_actual equals the expected entry.
REQ-016 SHALL have port busy  output  1  scan in progress.
REQ-017 SHALL have port done  output  1  scan complete; held until next accepted start.
REQ-018 SHALL have port errors  output  6  mismatch count of the last or current scan.

Function
REQ-019 SHALL hold a NUM_REGS x DATA_W expected table written on clk when exp_we=1 and busy=0.
REQ-020 SHALL drop exp_we writes while busy=1, leaving the table unchanged.
REQ-021 SHALL implement FSM states IDLE, ISSUE, CAPTURE, EMIT, DONE.
REQ-022 SHALL, in IDLE or DONE, on start=1: clear errors, set idx=0, clear done, enter ISSUE.
REQ-023 SHALL ignore start while in ISSUE, CAPTURE or EMIT.
REQ-024 SHALL, in ISSUE, drive rf_raddr=idx and enter CAPTURE next cycle.
REQ-025 SHALL, in CAPTURE, register rf_rdata into out_actual, compute out_match, and increment errors on mismatch, then enter EMIT.
REQ-026 SHALL keep rf_raddr=idx in both ISSUE and CAPTURE.
REQ-027 SHALL, in EMIT, assert out_valid with out_idx, out_actual and out_match held stable until out_ready=1.
REQ-028 SHALL, on an EMIT cycle with out_ready=1: if idx=NUM_REGS-1, enter DONE, else set idx=idx+1 and enter ISSUE.
REQ-029 SHALL compare all registers including r0; no index is special-cased.
REQ-030 SHALL take exactly 3 cycles per register from ISSUE to EMIT acceptance when out_ready is held at 1, for 3*NUM_REGS cycles per scan.
REQ-031 SHALL, in DONE, assert done=1, busy=0, out_valid=0, and hold errors stable.
REQ-032 SHALL assert busy=1 exactly in ISSUE, CAPTURE and EMIT.
REQ-033 SHALL produce an errors value of at most NUM_REGS with no wrap; 6 bits suffice for 32.
REQ-034 SHALL drive rf_raddr=0 in IDLE and DONE.

Reset
REQ-035 SHALL, on rstb=0 at any time including mid-scan, asynchronously force: state=IDLE, idx=0, out_valid=0, busy=0, done=0, errors=0, rf_raddr=0, out_idx=0, out_actual=0, out_match=0.
REQ-036 SHALL not clear the expected table on reset; its contents are undefined until written.
REQ-037 SHALL resume normal operation on the first rising clk after rstb deasserts.

Verification
REQ-038 Load table[i]=i, model RF returns i, start, out_ready=1 -> 32 beats, idx 0..31 in order, all out_match=1, errors=0, done at cycle 96 after start.
REQ-039 As REQ-038 with RF returning 0xDEADBEEF for r5 and r31 -> out_match=0 on beats 5 and 31, errors=2, done=1.
REQ-040 Random out_ready low periods of 0-7 cycles -> out_idx/out_actual/out_match stable while stalled, no beat lost or duplicated, 32 beats total.
REQ-041 Pulse start and exp_we (addr 3, data 0xFFFFFFFF) mid-scan -> scan unaffected, table[3] unchanged, errors equals the no-disturbance result.
REQ-042 Drop rstb at beat 10 -> all outputs return to reset values immediately; a new start then gives a full 32-beat scan from idx 0.
REQ-043 Two back-to-back scans, one with 32 mismatches then one with 0 -> errors=32 then errors=0, done held between scans until the second start.
